keypad_scan: RTL and testbench

KEYPAD_SCAN -- requirements
Module: keypad_scan

---
 rtl/keypad_pkg.sv | 28 ++
 rtl/keypad_debounce.sv | 94 +++++++++
 rtl/keypad_scan.sv | 103 ++++++++++
 tb/tb_keypad_scan.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared constants and types for the 4x4 matrix keypad scanner.
//   KP_ROWS / KP_COLS / KP_KEYS : matrix geometry
//   key_idx_t                   : 4-bit key index, {row[1:0], col[1:0]}
//   key_vec_t                   : 16-bit key vector, bit r*4+c = row r, col c
//   lowest_set()                : index of the lowest set bit of a key vector
// -----------------------------------------------------------------------------
package keypad_pkg;

   localparam int KP_ROWS = 4;
   localparam int KP_COLS = 4;
   localparam int KP_KEYS = 16;

   typedef logic [3:0]         key_idx_t;
   typedef logic [KP_KEYS-1:0] key_vec_t;

   // Scans from the top so the last hit written is the lowest index.
   function automatic key_idx_t lowest_set(input key_vec_t v);
      key_idx_t idx;
      idx = '0;
      for (int i = KP_KEYS - 1; i >= 0; i--) begin
         if (v[i]) idx = key_idx_t'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/keypad_debounce.sv
// -----------------------------------------------------------------------------
// keypad_debounce
// Frame-level debouncer: a complete scan frame is accepted into key only after
// DEBOUNCE_N consecutive identical frames. Press and release share the rule.
// Optional new-press event output when KEYPAD_EVENT_EN is defined.
//   clk, rst_n   : clock, synchronous active-low reset
//   frame        : complete scan frame (valid when frame_end is high)
//   frame_end    : one-cycle strobe marking the last sample of a frame
//   key          : debounced key level vector
//   key_press    : (KEYPAD_EVENT_EN) one-cycle pulse on a new press
//   key_code     : (KEYPAD_EVENT_EN) index of lowest newly pressed key
// -----------------------------------------------------------------------------
module keypad_debounce
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE_N = 3
) (
   input  logic     clk,
   input  logic     rst_n,
   input  key_vec_t frame,
   input  logic     frame_end,
   output key_vec_t key
`ifdef KEYPAD_EVENT_EN
   ,
   output logic     key_press,
   output key_idx_t key_code
`endif
);

   localparam logic [3:0] CNT_MAX = 4'd15;
   localparam logic [3:0] DB_N    = 4'(DEBOUNCE_N);

   key_vec_t    last_frame_q, last_frame_d;
   logic [3:0]  stable_cnt_q, stable_cnt_d;
   key_vec_t    key_q, key_d;

   always_comb begin
      last_frame_d = last_frame_q;
      stable_cnt_d = stable_cnt_q;
      key_d        = key_q;
      if (frame_end) begin
         if (frame == last_frame_q) begin
            stable_cnt_d = (stable_cnt_q == CNT_MAX) ? CNT_MAX : stable_cnt_q + 4'd1;
         end else begin
            stable_cnt_d = 4'd1;
         end
         last_frame_d = frame;
         if (stable_cnt_d >= DB_N) key_d = frame;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_frame_q <= '0;
         stable_cnt_q <= '0;
         key_q        <= '0;
      end else begin
         last_frame_q <= last_frame_d;
         stable_cnt_q <= stable_cnt_d;
         key_q        <= key_d;
      end
   end

   assign key = key_q;

`ifdef KEYPAD_EVENT_EN
   key_vec_t new_bits;
   logic     key_press_q, key_press_d;
   key_idx_t key_code_q, key_code_d;

   // Only 0->1 transitions of the debounced vector count as a new press;
   // registering alongside key_q keeps the pulse coincident with the update.
   always_comb begin
      new_bits    = key_d & ~key_q;
      key_press_d = |new_bits;
      key_code_d  = key_code_q;
      if (|new_bits) key_code_d = lowest_set(new_bits);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         key_press_q <= 1'b0;
         key_code_q  <= '0;
      end else begin
         key_press_q <= key_press_d;
         key_code_q  <= key_code_d;
      end
   end

   assign key_press = key_press_q;
   assign key_code  = key_code_q;
`endif

endmodule

// File: rtl/keypad_scan.sv
// -----------------------------------------------------------------------------
// keypad_scan
// 4x4 matrix keypad scanner. Drives one column low at a time for SCAN_DIV
// cycles, samples the synchronised rows at the end of each column slot and
// hands complete frames to keypad_debounce.
// Optional macro: KEYPAD_EVENT_EN adds key_press / key_code outputs.
//   clk      : system clock, rising edge
//   rst_n    : synchronous active-low reset
//   row_in   : keypad rows, active-low, asynchronous to clk
//   col_out  : column drive, active-low, one-hot-low
//   key      : debounced key levels, bit r*4+c
//   key_press: (KEYPAD_EVENT_EN) one-cycle new-press pulse
//   key_code : (KEYPAD_EVENT_EN) index of the newly pressed key
// -----------------------------------------------------------------------------
module keypad_scan
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV   = 50_000,
   parameter int DEBOUNCE_N = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] row_in,
   output logic [3:0] col_out,
   output logic [15:0] key
`ifdef KEYPAD_EVENT_EN
   ,
   output logic       key_press,
   output logic [3:0] key_code
`endif
);

   localparam int                CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0]  SLOT_LAST = CNT_W'(SCAN_DIV - 1);

   logic [3:0]       row_meta_q, row_meta_d;
   logic [3:0]       row_sync_q, row_sync_d;
   logic [CNT_W-1:0] slot_q, slot_d;
   logic [1:0]       col_idx_q, col_idx_d;
   logic [3:0]       col_out_q, col_out_d;
   key_vec_t         frame_q, frame_d;
   logic             wrap;
   logic             frame_end;

   always_comb begin
      row_meta_d = row_in;
      row_sync_d = row_meta_q;

      wrap      = (slot_q == SLOT_LAST);
      frame_end = wrap && (col_idx_q == 2'd3);

      slot_d    = wrap ? '0 : slot_q + CNT_W'(1);
      col_idx_d = wrap ? col_idx_q + 2'd1 : col_idx_q;
      col_out_d = ~(4'b0001 << col_idx_d);

      // Sampling on the last slot cycle leaves SCAN_DIV-3 cycles for the
      // column drive to reach the rows and cross the synchroniser.
      frame_d = frame_q;
      if (wrap) begin
         for (int r = 0; r < KP_ROWS; r++) begin
            frame_d[{2'(r), col_idx_q}] = ~row_sync_q[r];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         row_meta_q <= 4'hF;
         row_sync_q <= 4'hF;
         slot_q     <= '0;
         col_idx_q  <= 2'd0;
         col_out_q  <= 4'b1110;
         frame_q    <= '0;
      end else begin
         row_meta_q <= row_meta_d;
         row_sync_q <= row_sync_d;
         slot_q     <= slot_d;
         col_idx_q  <= col_idx_d;
         col_out_q  <= col_out_d;
         frame_q    <= frame_d;
      end
   end

   assign col_out = col_out_q;

   // frame_d already carries the column-3 sample taken this cycle, so the
   // debouncer sees the complete frame on the frame_end strobe.
   keypad_debounce #(
      .DEBOUNCE_N (DEBOUNCE_N)
   ) u_debounce (
      .clk       (clk),
      .rst_n     (rst_n),
      .frame     (frame_d),
      .frame_end (frame_end),
      .key       (key)
`ifdef KEYPAD_EVENT_EN
      ,
      .key_press (key_press),
      .key_code  (key_code)
`endif
   );

endmodule

// File: tb/tb_keypad_scan.sv
// -----------------------------------------------------------------------------
// tb_keypad_scan
// Directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_N=3 (16-cycle
// frames). A combinational keypad matrix model turns the pressed-key vector
// and col_out into row_in. Cycle 0 is the first cycle after rst_n rises;
// frame ends fall on cycles 15, 31, 47, ... and key updates one cycle later.
// -----------------------------------------------------------------------------
module tb_keypad_scan;

   localparam int SCAN_DIV   = 4;
   localparam int DEBOUNCE_N = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  row_in;
   logic [3:0]  col_out;
   logic [15:0] key;
   logic [15:0] pressed = 16'h0000;

   int n_cmp = 0;
   int n_err = 0;

`ifdef KEYPAD_EVENT_EN
   logic        key_press;
   logic [3:0]  key_code;
   int          pulses = 0;
   int          pulse_base;
`endif

   always #5 clk = ~clk;

   // A row reads low when any pressed key on it sits in the driven column.
   always_comb begin
      row_in = 4'hF;
      for (int r = 0; r < 4; r++) begin
         row_in[r] = ~|(pressed[r*4 +: 4] & ~col_out);
      end
   end

   keypad_scan #(
      .SCAN_DIV   (SCAN_DIV),
      .DEBOUNCE_N (DEBOUNCE_N)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .row_in    (row_in),
      .col_out   (col_out),
      .key       (key)
`ifdef KEYPAD_EVENT_EN
      ,
      .key_press (key_press),
      .key_code  (key_code)
`endif
   );

`ifdef KEYPAD_EVENT_EN
   always @(negedge clk) begin
      if (key_press === 1'b1) pulses++;
   end
`endif

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Leaves the bench in cycle 0 with rst_n high.
   task automatic do_reset();
      rst_n = 1'b0;
      step(3);
      rst_n = 1'b1;
   endtask

   initial begin
      // Reset state
      rst_n = 1'b0;
      step(3);
      check("rst_col_out", {12'h0, col_out}, 16'h000E);
      check("rst_key", key, 16'h0000);
`ifdef KEYPAD_EVENT_EN
      check("rst_key_press", {15'h0, key_press}, 16'h0000);
      check("rst_key_code", {12'h0, key_code}, 16'h0000);
`endif

      // Idle rows: column walk, key stays clear
      rst_n = 1'b1;
      check("idle_col_c0", {12'h0, col_out}, 16'h000E);
      step(3);
      check("idle_col_c3", {12'h0, col_out}, 16'h000E);
      step(1);
      check("idle_col_c4", {12'h0, col_out}, 16'h000D);
      step(4);
      check("idle_col_c8", {12'h0, col_out}, 16'h000B);
      step(4);
      check("idle_col_c12", {12'h0, col_out}, 16'h0007);
      step(4);
      check("idle_col_c16", {12'h0, col_out}, 16'h000E);
      step(32);
      check("idle_key_c48", key, 16'h0000);

      // Hold row1/col2 from cycle 0: key appears at cycle 48 only
      pressed = 16'h0040;
      do_reset();
      step(16);
      check("hold_key_c16", key, 16'h0000);
      step(16);
      check("hold_key_c32", key, 16'h0000);
      step(15);
      check("hold_key_c47", key, 16'h0000);
      step(1);
      check("hold_key_c48", key, 16'h0040);

      // Reset mid-frame at col_idx 2
      step(9);
      check("mid_col_c57", {12'h0, col_out}, 16'h000B);
      check("mid_key_c57", key, 16'h0040);
      rst_n = 1'b0;
      step(1);
      check("mid_rst_key", key, 16'h0000);
      check("mid_rst_col", {12'h0, col_out}, 16'h000E);
      pressed = 16'h0000;
      rst_n = 1'b1;
      step(3);
      check("restart_col_c3", {12'h0, col_out}, 16'h000E);
      step(1);
      check("restart_col_c4", {12'h0, col_out}, 16'h000D);

      // Key 6 held for exactly two frames never reaches key
      pressed = 16'h0000;
      do_reset();
      pressed = 16'h0040;
      for (int i = 1; i <= 20; i++) begin
         step(4);
         check("glitch_key", key, 16'h0000);
         if (i == 8) pressed = 16'h0000;
      end

      // Keys 0 and 15 together, then released together
      pressed = 16'h8001;
      do_reset();
      step(47);
      check("multi_key_c47", key, 16'h0000);
      step(1);
      check("multi_key_c48", key, 16'h8001);
      pressed = 16'h0000;
      step(47);
      check("release_key_c95", key, 16'h8001);
      step(1);
      check("release_key_c96", key, 16'h0000);

`ifdef KEYPAD_EVENT_EN
      // New-press events: 5, then 9 added, then 5 released
      pressed = 16'h0020;
      do_reset();
      pulse_base = pulses;
      step(48);
      check("ev5_key", key, 16'h0020);
      check("ev5_press", {15'h0, key_press}, 16'h0001);
      check("ev5_code", {12'h0, key_code}, 16'h0005);
      pressed = 16'h0220;
      step(1);
      check("ev5_press_end", {15'h0, key_press}, 16'h0000);
      check("ev5_code_hold", {12'h0, key_code}, 16'h0005);
      step(47);
      check("ev9_key", key, 16'h0220);
      check("ev9_press", {15'h0, key_press}, 16'h0001);
      check("ev9_code", {12'h0, key_code}, 16'h0009);
      pressed = 16'h0200;
      step(48);
      check("rel5_key", key, 16'h0200);
      check("rel5_press", {15'h0, key_press}, 16'h0000);
      check("rel5_code", {12'h0, key_code}, 16'h0009);
      step(4);
      check("ev_pulse_count", 16'(pulses - pulse_base), 16'd2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
